// File: rtl/pll_reconfig_pkg.sv
// PLL reconfiguration sequencer shared definitions.
// Holds register map, C-counter field position and FSM encoding.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    localparam int C_SEL_SHIFT = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_START,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    // C-counter word: counter index above the 18-bit counter value.
    function automatic logic [31:0] c_word(
        input logic [4:0]  sel,
        input logic [17:0] c
    );
        return 32'(c) | (32'(sel) << C_SEL_SHIFT);
    endfunction

endpackage

// File: rtl/pll_reconfig_sequencer_if.sv
// Config handshake and Avalon-MM reconfig port of the sequencer.
// master: sequencer side; slave: config source + reconfig controller.
interface pll_reconfig_sequencer_if;

    logic        cfg_valid;
    logic        cfg_ready;
    logic [17:0] cfg_m;
    logic [17:0] cfg_n;
    logic [17:0] cfg_c;

    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        input  cfg_valid,
        input  cfg_m,
        input  cfg_n,
        input  cfg_c,
        output cfg_ready,
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        output cfg_valid,
        output cfg_m,
        output cfg_n,
        output cfg_c,
        input  cfg_ready,
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/pll_lock_timer.sv
// Lock-wait cycle counter with timeout compare.
// Ports: clk, reset_n, clear, enable -> count[15:0], expired.
module pll_lock_timer #(
    parameter int unsigned LIMIT = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count,
    output logic        expired
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == 16'(LIMIT));

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Writes M/N/C counters to a PLL reconfig controller, starts it, waits for relock.
// Ports: clk, reset_n, bus (cfg handshake + Avalon-MM), pll_locked, busy, done, error.
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned C_SEL         = 0,
    parameter int unsigned MIN_LOCK_WAIT = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pll_reconfig_sequencer_if.master bus,
    input  logic                     pll_locked,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    state_t      state;
    state_t      state_nxt;
    logic [17:0] m_q;
    logic [17:0] n_q;
    logic [17:0] c_q;
    logic        accept;
    logic        lock_ok;
    logic        expired;
    logic [15:0] count;
    logic        in_wait;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;

    assign accept  = (state == S_IDLE) && bus.cfg_valid;
    assign in_wait = (state == S_WAIT_LOCK);
    assign lock_ok = pll_locked && (count >= 16'(MIN_LOCK_WAIT));

    // Counter is held at zero outside WAIT_LOCK, so it reads 0 on entry.
    pll_lock_timer #(
        .LIMIT (LOCK_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_wait),
        .enable  (in_wait),
        .count   (count),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q <= '0;
            n_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            m_q <= bus.cfg_m;
            n_q <= bus.cfg_n;
            c_q <= bus.cfg_c;
        end
    end

    // Lock is tested before timeout, so a same-cycle tie ends in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else if (accept) begin
            error <= 1'b0;
        end else if (in_wait && !lock_ok && expired) begin
            error <= 1'b1;
        end
    end

    // Address/data derive only from state and captured counters,
    // so they cannot move while the controller stalls.
    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        addr      = ADDR_MODE;
        data      = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_WR_MODE;
            end
            S_WR_MODE: begin
                wr   = 1'b1;
                addr = ADDR_MODE;
                data = '0;
                if (!bus.mgmt_waitrequest) state_nxt = S_WR_N;
            end
            S_WR_N: begin
                wr   = 1'b1;
                addr = ADDR_N;
                data = 32'(n_q);
                if (!bus.mgmt_waitrequest) state_nxt = S_WR_M;
            end
            S_WR_M: begin
                wr   = 1'b1;
                addr = ADDR_M;
                data = 32'(m_q);
                if (!bus.mgmt_waitrequest) state_nxt = S_WR_C;
            end
            S_WR_C: begin
                wr   = 1'b1;
                addr = ADDR_C;
                data = c_word(5'(C_SEL), c_q);
                if (!bus.mgmt_waitrequest) state_nxt = S_WR_START;
            end
            S_WR_START: begin
                wr   = 1'b1;
                addr = ADDR_START;
                data = 32'd1;
                if (!bus.mgmt_waitrequest) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_nxt = S_DONE;
                end else if (expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.mgmt_write     = wr;
    assign bus.mgmt_address   = addr;
    assign bus.mgmt_writedata = data;
    assign bus.cfg_ready      = (state == S_IDLE);
    assign busy               = (state != S_IDLE);
    assign done               = (state == S_DONE);

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Randomized bench for pll_reconfig_sequencer against a transaction-level model.
// Two instances (C_SEL 0 and 4) see identical stimulus.
module tb_pll_reconfig_sequencer;

    localparam int TO   = 100;
    localparam int MINW = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [17:0] cfg_m = '0;
    logic [17:0] cfg_n = '0;
    logic [17:0] cfg_c = '0;
    logic        waitreq = 1'b0;
    logic        pll_locked = 1'b0;
    logic        busy0, done0, error0;
    logic        busy4, done4, error4;

    int n_vec = 0;
    int n_err = 0;

    pll_reconfig_sequencer_if bus0 ();
    pll_reconfig_sequencer_if bus4 ();

    assign bus0.cfg_valid        = cfg_valid;
    assign bus0.cfg_m            = cfg_m;
    assign bus0.cfg_n            = cfg_n;
    assign bus0.cfg_c            = cfg_c;
    assign bus0.mgmt_waitrequest = waitreq;
    assign bus4.cfg_valid        = cfg_valid;
    assign bus4.cfg_m            = cfg_m;
    assign bus4.cfg_n            = cfg_n;
    assign bus4.cfg_c            = cfg_c;
    assign bus4.mgmt_waitrequest = waitreq;

    always #5 clk = ~clk;

    pll_reconfig_sequencer #(
        .C_SEL         (0),
        .MIN_LOCK_WAIT (MINW),
        .LOCK_TIMEOUT  (TO)
    ) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus0),
        .pll_locked (pll_locked),
        .busy       (busy0),
        .done       (done0),
        .error      (error0)
    );

    pll_reconfig_sequencer #(
        .C_SEL         (4),
        .MIN_LOCK_WAIT (MINW),
        .LOCK_TIMEOUT  (TO)
    ) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus4),
        .pll_locked (pll_locked),
        .busy       (busy4),
        .done       (done4),
        .error      (error4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Expected write w of a sequence, straight from the register map.
    function automatic logic [31:0] exp_addr(input int w);
        case (w)
            0: return 32'h00;
            1: return 32'h03;
            2: return 32'h04;
            3: return 32'h05;
            default: return 32'h02;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(input int w, input int csel,
        input logic [17:0] m, input logic [17:0] n, input logic [17:0] c);
        case (w)
            0: return 32'd0;
            1: return 32'(n);
            2: return 32'(m);
            3: return 32'(c) + 32'(csel) * 32'd262144;
            default: return 32'd1;
        endcase
    endfunction

    task automatic check_status(input string tag, input int busy_e,
                                input int done_e, input int ready_e);
        check({tag, "_busy0"}, 32'(busy0), busy_e);
        check({tag, "_busy4"}, 32'(busy4), busy_e);
        check({tag, "_done0"}, 32'(done0), done_e);
        check({tag, "_done4"}, 32'(done4), done_e);
        check({tag, "_rdy0"}, 32'(bus0.cfg_ready), ready_e);
        check({tag, "_rdy4"}, 32'(bus4.cfg_ready), ready_e);
    endtask

    task automatic check_nowrite(input string tag);
        check({tag, "_wr0"}, 32'(bus0.mgmt_write), 0);
        check({tag, "_wr4"}, 32'(bus4.mgmt_write), 0);
    endtask

    // One offered set. st_wr<0 picks random stalls for the first four
    // writes; rst_at>=0 pulls reset during that cycle of the start stall.
    task automatic run_seq(input logic [17:0] m, input logic [17:0] n,
        input logic [17:0] c, input int st_wr, input int st_start,
        input int lock_at, input bit hold, input int rst_at);
        int s_n;
        int dec;
        int last;
        bit ok;
        check_status("offer", 0, 0, 1);
        cfg_valid  = 1'b1;
        cfg_m      = m;
        cfg_n      = n;
        cfg_c      = c;
        pll_locked = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("acc_err0", 32'(error0), 0);
        check("acc_err4", 32'(error4), 0);
        for (int w = 0; w < 5; w++) begin
            if (w == 4) s_n = st_start;
            else if (st_wr < 0) s_n = int'($urandom_range(0, 3));
            else s_n = st_wr;
            for (int s = 0; s <= s_n; s++) begin
                cfg_valid = hold;
                if (hold) begin
                    cfg_m = 18'($urandom);
                    cfg_n = 18'($urandom);
                    cfg_c = 18'($urandom);
                end
                waitreq    = (s < s_n);
                pll_locked = 1'($urandom_range(0, 1));
                if (w == 4 && s == rst_at) begin
                    #2 reset_n = 1'b0;
                    #1;
                    check_nowrite("rst_now");
                    check("rst_addr", 32'(bus0.mgmt_address), 0);
                    check("rst_data", bus0.mgmt_writedata, 0);
                    check("rst_err", 32'(error0), 0);
                    check_status("rst_now", 0, 0, 1);
                    waitreq   = 1'b0;
                    cfg_valid = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        check_nowrite("post_rst");
                        check_status("post_rst", 0, 0, 1);
                    end
                    return;
                end
                check_status("wr", 1, 0, 0);
                check("wr_en0", 32'(bus0.mgmt_write), 1);
                check("wr_en4", 32'(bus4.mgmt_write), 1);
                check("wr_addr0", 32'(bus0.mgmt_address), exp_addr(w));
                check("wr_addr4", 32'(bus4.mgmt_address), exp_addr(w));
                check("wr_data0", bus0.mgmt_writedata,
                      exp_data(w, 0, m, n, c));
                check("wr_data4", bus4.mgmt_writedata,
                      exp_data(w, 4, m, n, c));
                @(negedge clk);
            end
        end
        waitreq = 1'b0;
        // Lock held from count lock_at onward; trusted from MINW.
        dec  = (lock_at > MINW) ? lock_at : MINW;
        ok   = (dec <= TO);
        last = ok ? dec + 1 : TO + 1;
        for (int k = 0; k <= last; k++) begin
            cfg_valid  = (k == last) ? 1'b0 : hold;
            pll_locked = (k >= lock_at);
            check_nowrite("wait");
            if (k < last) begin
                check_status("wait", 1, 0, 0);
            end else if (ok) begin
                check_status("done", 1, 1, 0);
            end else begin
                check_status("tmo", 0, 0, 1);
                check("tmo_err0", 32'(error0), 1);
                check("tmo_err4", 32'(error4), 1);
            end
            @(negedge clk);
        end
        check_status("after", 0, 0, 1);
        check("after_err0", 32'(error0), ok ? 0 : 1);
        check("after_err4", 32'(error4), ok ? 0 : 1);
        check_nowrite("after");
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_nowrite("reset");
        check("reset_addr", 32'(bus0.mgmt_address), 0);
        check("reset_data", bus0.mgmt_writedata, 0);
        check("reset_err", 32'(error0), 0);
        check_status("reset", 0, 0, 1);
        reset_n = 1'b1;
        @(negedge clk);

        run_seq(18'h20706, 18'h00101, 18'h20302, 0, 0, 0, 1'b0, -1);
        run_seq(18'h3ABCD, 18'h01234, 18'h2FFFF, 3, 50, 20, 1'b1, -1);
        run_seq(18'h00505, 18'h00202, 18'h10101, 1, 2, 1000, 1'b0, -1);
        run_seq(18'h11111, 18'h22222, 18'h10101, 0, 0, 100, 1'b1, -1);
        run_seq(18'h33333, 18'h00001, 18'h3FFFF, 0, 5, 101, 1'b0, -1);
        run_seq(18'h0F0F0, 18'h30303, 18'h12345, 2, 30, 0, 1'b1, 10);
        run_seq(18'h20706, 18'h00101, 18'h20302, 0, 0, 5, 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            run_seq(18'($urandom), 18'($urandom), 18'($urandom), -1,
                    int'($urandom_range(0, 50)),
                    int'($urandom_range(0, 110)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ?
                        int'($urandom_range(0, 5)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
